// File: rtl/run_sequencer_if.sv
// Handshake bundle between the run sequencer and its controller.
// The controller side (master) drives start/done; the sequencer (slave)
// returns the run status and the cycle counter.
interface run_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             done;
    logic             run_en;
    logic             pc_clear;
    logic             ack;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output start, done,
        input  run_en, pc_clear, ack, timeout, cycle_count
    );

    modport slave (
        input  start, done,
        output run_en, pc_clear, ack, timeout, cycle_count
    );
endinterface

// File: rtl/run_sequencer.sv
// Run sequencer: arms a program run on start, gates execution while running,
// and acknowledges completion on done or on the optional watchdog limit.
// Optional feature: define RUN_SEQ_WATCHDOG_EN to enable the MAX_CYCLES
// watchdog and the timeout flag; without it a run ends only on done and the
// cycle counter saturates at its all-ones value.
module run_sequencer #(
    parameter int MAX_CYCLES = 4096,
    parameter int CNT_W      = 16
) (
    input  logic           clk,
    input  logic           reset,
    run_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        RUN   = 2'b10,
        ACK   = 2'b11
    } state_t;

    // Reject configurations whose counter cannot hold the watchdog limit.
    if (MAX_CYCLES < 2 || (64'd1 << CNT_W) <= 64'(MAX_CYCLES)) begin : g_bad_cfg
        $error("run_sequencer: need MAX_CYCLES >= 2 and 2**CNT_W > MAX_CYCLES");
    end

`ifdef RUN_SEQ_WATCHDOG_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    // Next-state and counter/flag update for the run handshake.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = ARMED;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            ARMED: begin
                cnt_d     = '0;
                timeout_d = 1'b0;
                if (!bus.start) state_d = RUN;
            end
            RUN: begin
`ifdef RUN_SEQ_WATCHDOG_EN
                // The counter tops out at MAX_CYCLES, so it can never wrap.
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.done) begin
                    state_d = ACK;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ACK;
                    timeout_d = 1'b1;
                end
`else
                if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                if (bus.done) state_d = ACK;
`endif
            end
            ACK: begin
                if (bus.start) begin
                    state_d   = ARMED;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and timeout registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Moore outputs: pure decodes of the registered state.
    assign bus.run_en      = (state_q == RUN);
    assign bus.pc_clear    = (state_q == ARMED);
    assign bus.ack         = (state_q == ACK);
    assign bus.timeout     = timeout_q;
    assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer. Works in both builds; define
// RUN_SEQ_WATCHDOG_EN to exercise the watchdog variant.
module tb_run_sequencer;

    localparam int MAX   = 16;
    localparam int CW    = 5;
    localparam int MAX_S = 8;
    localparam int CW_S  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    run_sequencer_if #(.CNT_W(CW))   bus ();
    run_sequencer_if #(.CNT_W(CW_S)) bus_s ();

    run_sequencer #(.MAX_CYCLES(MAX), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    run_sequencer #(.MAX_CYCLES(MAX_S), .CNT_W(CW_S)) dut_s (
        .clk(clk), .reset(reset), .bus(bus_s)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: outcome of one run given the RUN cycle on which done is
    // raised (0 = never). Returns run length, final count and timeout flag.
    function automatic void model(input int done_at, output int len,
                                  output int cnt, output bit to);
`ifdef RUN_SEQ_WATCHDOG_EN
        if (done_at == 0 || done_at > MAX) begin
            len = MAX; to = 1'b1;
        end else begin
            len = done_at; to = 1'b0;
        end
        cnt = len;
`else
        len = done_at;
        to  = 1'b0;
        cnt = (done_at > (1 << CW) - 1) ? (1 << CW) - 1 : done_at;
`endif
    endfunction

    // One full run on the main DUT from IDLE or ACK: arm for 'arm' cycles,
    // then run until the sequencer leaves RUN, raising done on cycle done_at.
    task automatic run_once(input int arm, input int done_at, input string name);
        int pcs = 0;
        int rc  = 0;
        int len, cnt;
        bit to;
        bit ended = 1'b0;
        model(done_at, len, cnt, to);
        bus.start = 1'b1;
        for (int i = 0; i < arm; i++) begin
            bus.done = 1'($urandom_range(0, 1));
            tick();
            if (bus.pc_clear) pcs++;
            if (i == 0) begin
                n_cmp++;
                if (bus.pc_clear !== 1'b1 || bus.cycle_count !== '0 || bus.timeout !== 1'b0 || bus.ack !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s arm_entry: pc_clear=%b cnt=%0d timeout=%b ack=%b, want 1/0/0/0",
                             name, bus.pc_clear, bus.cycle_count, bus.timeout, bus.ack);
                end
            end
        end
        bus.start = 1'b0;
        bus.done  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!bus.run_en) begin
                ended = 1'b1;
                break;
            end
            rc++;
            bus.done  = (rc == done_at);
            bus.start = 1'($urandom_range(0, 1));
        end
        bus.start = 1'b0;
        bus.done  = 1'b0;
        n_cmp++;
        if (!ended) begin
            n_bad++;
            $display("FAIL %s run_end: still running after 200 cycles, want end after %0d", name, len);
        end
        n_cmp++;
        if (pcs != arm) begin
            n_bad++;
            $display("FAIL %s pc_clear_cycles: got %0d want %0d", name, pcs, arm);
        end
        n_cmp++;
        if (rc != len) begin
            n_bad++;
            $display("FAIL %s run_en_cycles: got %0d want %0d", name, rc, len);
        end
        n_cmp++;
        if (bus.ack !== 1'b1 || bus.pc_clear !== 1'b0) begin
            n_bad++;
            $display("FAIL %s ack: ack=%b pc_clear=%b want 1/0", name, bus.ack, bus.pc_clear);
        end
        n_cmp++;
        if (bus.cycle_count !== CW'(cnt)) begin
            n_bad++;
            $display("FAIL %s cycle_count: got %0d want %0d", name, bus.cycle_count, cnt);
        end
        n_cmp++;
        if (bus.timeout !== to) begin
            n_bad++;
            $display("FAIL %s timeout: got %b want %b", name, bus.timeout, to);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.done = 1'b0;
        bus_s.start = 1'b0; bus_s.done = 1'b0;
        #3;
        n_cmp++;
        if ({bus.run_en, bus.pc_clear, bus.ack, bus.timeout} !== 4'b0 || bus.cycle_count !== '0) begin
            n_bad++;
            $display("FAIL reset_async: outputs=%b cnt=%0d want all 0",
                     {bus.run_en, bus.pc_clear, bus.ack, bus.timeout}, bus.cycle_count);
        end
        tick();
        tick();
        @(negedge clk);
        reset = 1'b0;
        tick();
        n_cmp++;
        if ({bus.run_en, bus.pc_clear, bus.ack, bus.timeout} !== 4'b0 || bus.cycle_count !== '0) begin
            n_bad++;
            $display("FAIL reset_idle: outputs=%b cnt=%0d want all 0",
                     {bus.run_en, bus.pc_clear, bus.ack, bus.timeout}, bus.cycle_count);
        end
    endtask

    task automatic test_directed();
        run_once(3, 5, "directed_done5");
    endtask

    task automatic test_boundary();
`ifdef RUN_SEQ_WATCHDOG_EN
        run_once(1, 0, "watchdog_expire");
        run_once(2, MAX, "done_at_terminal");
        run_once(1, MAX + 1, "done_after_terminal");
        run_once(1, MAX - 1, "done_before_terminal");
`else
        run_once(1, MAX, "done_at_16");
        run_once(2, (1 << CW) + 3, "count_saturate");
`endif
    endtask

    task automatic test_ack_hold();
`ifdef RUN_SEQ_WATCHDOG_EN
        run_once(1, 0, "pre_hold");
`else
        run_once(1, 20, "pre_hold");
`endif
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.done = 1'($urandom_range(0, 1));
            tick();
            n_cmp++;
            if (bus.ack !== 1'b1 || bus.run_en !== 1'b0) begin
                n_bad++;
                $display("FAIL ack_hold cycle %0d: ack=%b run_en=%b want 1/0", i, bus.ack, bus.run_en);
            end
        end
        bus.done  = 1'b0;
        bus.start = 1'b1;
        tick();
        n_cmp++;
        if (bus.ack !== 1'b0 || bus.pc_clear !== 1'b1 || bus.cycle_count !== '0 || bus.timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL rearm: ack=%b pc_clear=%b cnt=%0d timeout=%b want 0/1/0/0",
                     bus.ack, bus.pc_clear, bus.cycle_count, bus.timeout);
        end
        run_once(1, 3, "after_rearm");
    endtask

    task automatic test_random();
        for (int r = 0; r < 20; r++) begin
            int arm = int'($urandom_range(1, 4));
`ifdef RUN_SEQ_WATCHDOG_EN
            int d = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, MAX + 4));
`else
            int d = int'($urandom_range(1, (1 << CW) + 6));
`endif
            run_once(arm, d, $sformatf("rand%0d", r));
        end
    endtask

    task automatic test_reset_mid_run();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        n_cmp++;
        if (bus.run_en !== 1'b1 || bus.cycle_count !== CW'(6)) begin
            n_bad++;
            $display("FAIL pre_reset_run: run_en=%b cnt=%0d want 1/6", bus.run_en, bus.cycle_count);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.run_en, bus.pc_clear, bus.ack, bus.timeout} !== 4'b0 || bus.cycle_count !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_run: outputs=%b cnt=%0d want all 0",
                     {bus.run_en, bus.pc_clear, bus.ack, bus.timeout}, bus.cycle_count);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.done = 1'b1;
            tick();
            n_cmp++;
            if ({bus.run_en, bus.pc_clear, bus.ack} !== 3'b0) begin
                n_bad++;
                $display("FAIL done_in_idle cycle %0d: run_en/pc_clear/ack=%b want 000",
                         i, {bus.run_en, bus.pc_clear, bus.ack});
            end
        end
        bus.done  = 1'b0;
        bus.start = 1'b1;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        n_cmp++;
        if (bus.pc_clear !== 1'b1 || bus.run_en !== 1'b0) begin
            n_bad++;
            $display("FAIL start_across_reset: pc_clear=%b run_en=%b want 1/0", bus.pc_clear, bus.run_en);
        end
        run_once(1, 2, "after_reset");
    endtask

    task automatic test_saturate();
        bus_s.start = 1'b1;
        tick();
        bus_s.start = 1'b0;
        tick();
`ifdef RUN_SEQ_WATCHDOG_EN
        begin
            int rc = 0;
            for (int i = 0; i < 40 && bus_s.run_en; i++) begin
                rc++;
                tick();
            end
            n_cmp++;
            if (rc != MAX_S || bus_s.ack !== 1'b1 || bus_s.timeout !== 1'b1 || bus_s.cycle_count !== CW_S'(MAX_S)) begin
                n_bad++;
                $display("FAIL small_watchdog: cycles=%0d ack=%b timeout=%b cnt=%0d want %0d/1/1/%0d",
                         rc, bus_s.ack, bus_s.timeout, bus_s.cycle_count, MAX_S, MAX_S);
            end
        end
`else
        for (int i = 0; i < 20; i++) tick();
        n_cmp++;
        if (bus_s.run_en !== 1'b1 || bus_s.cycle_count !== CW_S'(15) || bus_s.timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL small_saturate: run_en=%b cnt=%0d timeout=%b want 1/15/0",
                     bus_s.run_en, bus_s.cycle_count, bus_s.timeout);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_boundary();
        test_ack_hold();
        test_random();
        test_reset_mid_run();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 Parameter MAX_CYCLES, default 4096, watchdog limit in RUN cycles per program run (>=2).
REQ-002 Parameter CNT_W, default 16, width of cycle counter; SHALL satisfy 2^CNT_W > MAX_CYCLES.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  testbench start request; level-sensitive.
REQ-006 done  input  1  decoded DONE instruction from control decoder; meaningful only in RUN.
REQ-007 run_en  output  1  high only in RUN; gates fetched instruction (low forces NOP).
REQ-008 pc_clear  output  1  high only in ARMED; synchronous clear to program counter.
REQ-009 ack  output  1  high only in ACK; run complete (normal or timeout).
REQ-010 timeout  output  1  high when the last run ended by watchdog.
REQ-011 cycle_count  output  CNT_W  RUN cycles elapsed in current/last run.

Function
REQ-012 States: IDLE, ARMED, RUN, ACK; run_en, pc_clear, ack SHALL be pure decodes of current state (Moore, no input-to-output path).
REQ-013 IDLE: start=1 -> ARMED next edge; else stay.
REQ-014 ARMED: stay while start=1; start=0 -> RUN next edge; on entry cycle_count<=0, timeout<=0.
REQ-015 RUN: cycle_count increments by 1 every cycle in RUN, including the exit cycle.
REQ-016 RUN: done=1 -> ACK next edge, timeout stays 0.
REQ-017 RUN: done=0 and cycle_count==MAX_CYCLES-1 -> ACK next edge with timeout<=1; run therefore lasts exactly MAX_CYCLES cycles.
REQ-018 RUN: done=1 coincident with terminal count -> done wins, timeout stays 0.
REQ-019 RUN: start ignored; no re-arm mid-run.
REQ-020 ACK: cycle_count and timeout hold; ack stays high until start=1, then -> ARMED (new run).
REQ-021 done ignored in IDLE, ARMED, ACK.
REQ-022 cycle_count never wraps; max value MAX_CYCLES.
REQ-023 Illegal state encodings SHALL recover to IDLE on next edge.

Reset
REQ-024 reset=1 forces IDLE immediately, independent of clk: run_en=0, pc_clear=0, ack=0, timeout=0, cycle_count=0.
REQ-025 Reset asserted mid-RUN or mid-ACK abandons the run; no ack issued; first edge after release evaluates from IDLE.
REQ-026 start held high across reset release -> ARMED on first edge after release.

Configuration
REQ-027 Macro RUN_SEQ_WATCHDOG_EN: when defined, REQ-017/018 apply and timeout is functional.
REQ-028 Without RUN_SEQ_WATCHDOG_EN: RUN exits only on done; timeout tied 0; cycle_count saturates at 2^CNT_W-1 and holds.

Verification
REQ-029 reset, start=1 for 3 cycles, start=0, done=1 on 5th RUN cycle -> pc_clear high 3 cycles, run_en high 5 cycles, ack=1 next cycle, cycle_count=5, timeout=0.
REQ-030 watchdog on, MAX_CYCLES=16, done never asserted -> run_en high exactly 16 cycles, ack=1, timeout=1, cycle_count=16.
REQ-031 MAX_CYCLES=16, done=1 on 16th RUN cycle -> ack=1, timeout=0, cycle_count=16.
REQ-032 after ack, hold start=0 for 10 cycles then start=1 -> ack held 10+ cycles, then ARMED: ack=0, pc_clear=1, cycle_count=0, timeout=0.
REQ-033 reset pulse mid-RUN (cycle 7) -> all outputs 0 same cycle, no ack; done pulse in IDLE -> no transition.
REQ-034 watchdog off, CNT_W=4, done never -> run_en stays high, cycle_count saturates at 15, timeout=0.
